// File: rtl/cic_ctrl_pkg.sv
// cic_ctrl_pkg
//   Shared definitions for the CIC decimator run-time controller.
//   CIC_DEC_WIDTH : default factor width parameter shared with the CIC
//                   (the factor bus is CIC_DEC_WIDTH+1 bits wide).
//   state_e       : reconfiguration FSM states.
//   is_legal_dec  : true for the factors the CIC supports (1,2,4,8,16).
package cic_ctrl_pkg;

  localparam int CIC_DEC_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_BND = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  // Takes a zero-extended 32-bit value so callers of any factor width can use it.
  function automatic logic is_legal_dec(input logic [31:0] factor);
    case (factor)
      32'd1, 32'd2, 32'd4, 32'd8, 32'd16: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating event counter with synchronous clear.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   inc_i          : count one event this cycle
//   clr_i          : clear; an event in the same cycle leaves the count at 1
//   count_o        : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? CNT_ONE : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl
//   Run-time controller for the CIC decimator. Accepts decimation-factor
//   change requests, lets the current output frame complete, then drains and
//   flushes the CIC before the new factor takes effect, so no output sample is
//   built from two factors. Also gathers saturation / dropped-sample stats.
//
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   cfg_valid_i           : factor change request
//   cfg_dec_factor_i      : requested factor
//   cfg_ready_o           : request can be accepted (idle in RUN)
//   cfg_err_o             : 1-cycle pulse, illegal factor rejected
//   cfg_done_o            : 1-cycle pulse, requested factor now active
//   s_valid_i             : upstream sample strobe (no back-pressure)
//   cic_valid_in_o        : gated sample strobe to the CIC
//   cic_dec_factor_o      : factor applied to the CIC
//   cic_rst_n_o           : registered active-low flush reset to the CIC
//   cic_overflow_i,
//   cic_underflow_i       : CIC saturation flags, qualified by cic_valid_out_i
//   cic_valid_out_i       : CIC output strobe
//   busy_o                : reconfiguration in progress
//   sat_sticky_o          : saturation seen since last clear
//   sat_cnt_o             : saturating count of saturated outputs
//   drop_cnt_o            : saturating count of samples dropped while reconfiguring
//   stat_clr_i            : clears sat_sticky_o, sat_cnt_o and drop_cnt_o
module cic_dec_ctrl #(
  parameter int DEC_WIDTH    = cic_ctrl_pkg::CIC_DEC_WIDTH,
  parameter int DEFAULT_DEC  = 1,
  parameter int DRAIN_CYCLES = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cfg_valid_i,
  input  logic [DEC_WIDTH:0]   cfg_dec_factor_i,
  output logic                 cfg_ready_o,
  output logic                 cfg_err_o,
  output logic                 cfg_done_o,
  input  logic                 s_valid_i,
  output logic                 cic_valid_in_o,
  output logic [DEC_WIDTH:0]   cic_dec_factor_o,
  output logic                 cic_rst_n_o,
  input  logic                 cic_overflow_i,
  input  logic                 cic_underflow_i,
  input  logic                 cic_valid_out_i,
  output logic                 busy_o,
  output logic                 sat_sticky_o,
  output logic [CNT_WIDTH-1:0] sat_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  input  logic                 stat_clr_i
);

  import cic_ctrl_pkg::*;

  localparam int FW   = DEC_WIDTH + 1;
  localparam int TMAX = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [FW-1:0] DEF_FACTOR = FW'(DEFAULT_DEC);
  localparam logic [FW-1:0] F_ONE      = FW'(1);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_CYCLES - 1);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [FW-1:0] phase_q, phase_d;
  logic [FW-1:0] dec_q, dec_d;
  logic [FW-1:0] pend_q, pend_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          cfg_err_q, cfg_err_d;
  logic          cfg_done_q, cfg_done_d;
  logic          cic_rst_n_q;
  logic          sat_sticky_q, sat_sticky_d;

  logic fwd;
  logic frame_end;
  logic drop_evt;
  logic sat_evt;

  // Samples reach the CIC only while it is running on a stable factor.
  assign fwd       = s_valid_i && ((state_q == ST_RUN) || (state_q == ST_WAIT_BND));
  // Mirrors the CIC's own decimation counter: this sample closes the frame.
  assign frame_end = fwd && (phase_q == (dec_q - F_ONE));
  assign drop_evt  = s_valid_i && ((state_q == ST_DRAIN) || (state_q == ST_FLUSH));
  assign sat_evt   = cic_valid_out_i && (cic_overflow_i || cic_underflow_i);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    dec_d        = dec_q;
    pend_d       = pend_q;
    tmr_d        = tmr_q;
    cfg_err_d    = 1'b0;
    cfg_done_d   = 1'b0;
    sat_sticky_d = sat_sticky_q;

    if (fwd) begin
      phase_d = frame_end ? '0 : (phase_q + F_ONE);
    end

    case (state_q)
      ST_RUN: begin
        if (cfg_valid_i) begin
          if (!is_legal_dec(32'(cfg_dec_factor_i))) begin
            cfg_err_d = 1'b1;
          end else if (cfg_dec_factor_i == dec_q) begin
            cfg_done_d = 1'b1;
          end else begin
            pend_d  = cfg_dec_factor_i;
            tmr_d   = '0;
            state_d = (phase_q == '0) ? ST_DRAIN : ST_WAIT_BND;
          end
        end
      end
      ST_WAIT_BND: begin
        if (frame_end) begin
          tmr_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tmr_q == DRAIN_LAST) begin
          tmr_d   = '0;
          dec_d   = pend_q;
          state_d = ST_FLUSH;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      ST_FLUSH: begin
        if (tmr_q == FLUSH_LAST) begin
          phase_d    = '0;
          cfg_done_d = 1'b1;
          state_d    = ST_RUN;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // A saturation event in the same cycle as a clear must survive it.
    if (sat_evt) begin
      sat_sticky_d = 1'b1;
    end else if (stat_clr_i) begin
      sat_sticky_d = 1'b0;
    end
  end

  // cic_rst_n follows the next state so the CIC sees reset for exactly the
  // cycles spent in FLUSH, and is held low while rst_n_i is asserted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_RUN;
      phase_q      <= '0;
      dec_q        <= DEF_FACTOR;
      pend_q       <= DEF_FACTOR;
      tmr_q        <= '0;
      cfg_err_q    <= 1'b0;
      cfg_done_q   <= 1'b0;
      cic_rst_n_q  <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      dec_q        <= dec_d;
      pend_q       <= pend_d;
      tmr_q        <= tmr_d;
      cfg_err_q    <= cfg_err_d;
      cfg_done_q   <= cfg_done_d;
      cic_rst_n_q  <= (state_d != ST_FLUSH);
      sat_sticky_q <= sat_sticky_d;
    end
  end

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (sat_evt),
    .clr_i   (stat_clr_i),
    .count_o (sat_cnt_o)
  );

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_drop_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (drop_evt),
    .clr_i   (stat_clr_i),
    .count_o (drop_cnt_o)
  );

  assign cfg_ready_o      = (state_q == ST_RUN);
  assign busy_o           = (state_q != ST_RUN);
  assign cfg_err_o        = cfg_err_q;
  assign cfg_done_o       = cfg_done_q;
  assign cic_valid_in_o   = fwd;
  assign cic_dec_factor_o = dec_q;
  assign cic_rst_n_o      = cic_rst_n_q;
  assign sat_sticky_o     = sat_sticky_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb_cic_dec_ctrl
//   Directed bench for cic_dec_ctrl. Every configuration request pushes the
//   pulse it should produce (err or done, factor, cycle) into a scoreboard
//   queue; a monitor pops and compares whenever cfg_done/cfg_err fire.
//   Counters are built 4 bits wide so saturation is reachable quickly.
module tb_cic_dec_ctrl;

  typedef struct {
    bit isErr;
    int factor;
    int cycle;
  } exp_t;

  logic       clk;
  logic       rstN;
  logic       cfgValid;
  logic [4:0] cfgDecFactor;
  logic       cfgReady;
  logic       cfgErr;
  logic       cfgDone;
  logic       sValid;
  logic       cicValidIn;
  logic [4:0] cicDecFactor;
  logic       cicRstN;
  logic       cicOverflow;
  logic       cicUnderflow;
  logic       cicValidOut;
  logic       busy;
  logic       satSticky;
  logic [3:0] satCnt;
  logic [3:0] dropCnt;
  logic       statClr;

  int   checkCount = 0;
  int   failCount  = 0;
  int   cyc        = 0;
  exp_t sbQ[$];

  cic_dec_ctrl #(
    .DEC_WIDTH    (4),
    .DEFAULT_DEC  (1),
    .DRAIN_CYCLES (4),
    .FLUSH_CYCLES (2),
    .CNT_WIDTH    (4)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rstN),
    .cfg_valid_i      (cfgValid),
    .cfg_dec_factor_i (cfgDecFactor),
    .cfg_ready_o      (cfgReady),
    .cfg_err_o        (cfgErr),
    .cfg_done_o       (cfgDone),
    .s_valid_i        (sValid),
    .cic_valid_in_o   (cicValidIn),
    .cic_dec_factor_o (cicDecFactor),
    .cic_rst_n_o      (cicRstN),
    .cic_overflow_i   (cicOverflow),
    .cic_underflow_i  (cicUnderflow),
    .cic_valid_out_i  (cicValidOut),
    .busy_o           (busy),
    .sat_sticky_o     (satSticky),
    .sat_cnt_o        (satCnt),
    .drop_cnt_o       (dropCnt),
    .stat_clr_i       (statClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request cycle; when track is set, the pulse it must cause is queued.
  task automatic applyStimulus(input int factor, input bit expErr, input int expFactor,
                               input int latency, input bit track);
    cfgValid     = 1'b1;
    cfgDecFactor = 5'(factor);
    if (track) sbQ.push_back('{isErr: expErr, factor: expFactor, cycle: cyc + latency});
    tick();
    cfgValid     = 1'b0;
    cfgDecFactor = '0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, sbQ.size(), 0);
    sbQ.delete();
  endtask

  // Monitor: every cfg pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstN && (cfgDone || cfgErr)) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_pulse", int'(cfgDone) + int'(cfgErr), 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_err_flag", int'(cfgErr), int'(e.isErr));
        checkOutput("sb_done_flag", int'(cfgDone), int'(!e.isErr));
        checkOutput("sb_factor", int'(cicDecFactor), e.factor);
        checkOutput("sb_cycle", cyc, e.cycle);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rstLow;
    int fwdWait;
    int fwdBusy;
    int busyCnt;
    int n;

    rstN = 1'b0; cfgValid = 1'b0; cfgDecFactor = '0; sValid = 1'b0;
    cicOverflow = 1'b0; cicUnderflow = 1'b0; cicValidOut = 1'b0; statClr = 1'b0;

    // Reset state
    tick(); tick();
    checkOutput("rst_cic_rst_n", int'(cicRstN), 0);
    checkOutput("rst_cfg_ready", int'(cfgReady), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cfg_done", int'(cfgDone), 0);
    checkOutput("rst_cfg_err", int'(cfgErr), 0);
    checkOutput("rst_dec", int'(cicDecFactor), 1);
    checkOutput("rst_sat_cnt", int'(satCnt), 0);
    checkOutput("rst_drop_cnt", int'(dropCnt), 0);
    checkOutput("rst_sticky", int'(satSticky), 0);
    rstN = 1'b1;
    tick();
    checkOutput("rel_cic_rst_n", int'(cicRstN), 1);

    // 1 -> 4 at phase 0 with continuous samples: 7-cycle latency, 6 drops
    $display("[TB] factor 1 -> 4");
    sValid = 1'b1;
    applyStimulus(4, 1'b0, 4, 7, 1'b1);
    checkOutput("s1_ready_drop", int'(cfgReady), 0);
    rstLow = 0; fwdBusy = 0;
    for (int i = 0; i < 6; i++) begin
      if (!cicRstN) rstLow++;
      if (cicValidIn) fwdBusy++;
      tick();
    end
    sValid = 1'b0;
    checkOutput("s1_rst_low_cycles", rstLow, 2);
    checkOutput("s1_fwd_while_busy", fwdBusy, 0);
    checkOutput("s1_drop_cnt", int'(dropCnt), 6);
    checkOutput("s1_dec", int'(cicDecFactor), 4);
    checkOutput("s1_busy_after", int'(busy), 0);
    waitDone("s1_done_timeout", 20);

    // 4 -> 8 at phase 0, no samples: no additional drops
    $display("[TB] factor 4 -> 8");
    applyStimulus(8, 1'b0, 8, 7, 1'b1);
    waitDone("s2a_done_timeout", 20);
    checkOutput("s2a_dec", int'(cicDecFactor), 8);
    checkOutput("s2a_drop_cnt", int'(dropCnt), 6);

    // 8 -> 2 requested while the phase-3 sample is accepted: 4 more samples forwarded
    $display("[TB] factor 8 -> 2 mid-frame");
    sValid = 1'b1;
    tick(); tick(); tick();
    applyStimulus(2, 1'b0, 2, 11, 1'b1);
    rstLow = 0; fwdWait = 0; fwdBusy = 0;
    for (int i = 0; i < 10; i++) begin
      if (cicValidIn) begin
        if (i < 4) fwdWait++;
        else fwdBusy++;
      end
      if (!cicRstN) rstLow++;
      if (i == 3) begin
        checkOutput("s2b_dec_in_wait", int'(cicDecFactor), 8);
        checkOutput("s2b_busy_in_wait", int'(busy), 1);
      end
      tick();
    end
    sValid = 1'b0;
    checkOutput("s2b_fwd_in_wait", fwdWait, 4);
    checkOutput("s2b_fwd_after_wait", fwdBusy, 0);
    checkOutput("s2b_rst_low_cycles", rstLow, 2);
    checkOutput("s2b_drop_cnt", int'(dropCnt), 12);
    checkOutput("s2b_dec", int'(cicDecFactor), 2);
    waitDone("s2b_done_timeout", 20);

    // Illegal factors
    $display("[TB] illegal factors");
    applyStimulus(6, 1'b1, 2, 1, 1'b1);
    checkOutput("s3_busy", int'(busy), 0);
    checkOutput("s3_ready", int'(cfgReady), 1);
    waitDone("s3_err_timeout", 5);
    checkOutput("s3_dec", int'(cicDecFactor), 2);
    applyStimulus(0, 1'b1, 2, 1, 1'b1);
    waitDone("s3_err0_timeout", 5);

    // Same-factor request at 16: immediate done, no flush, no drops
    $display("[TB] same factor 16");
    applyStimulus(16, 1'b0, 16, 7, 1'b1);
    waitDone("s4a_done_timeout", 20);
    sValid = 1'b1;
    applyStimulus(16, 1'b0, 16, 1, 1'b1);
    rstLow = 0; busyCnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (!cicRstN) rstLow++;
      if (busy) busyCnt++;
      tick();
    end
    sValid = 1'b0;
    checkOutput("s4_rst_low_cycles", rstLow, 0);
    checkOutput("s4_busy_cycles", busyCnt, 0);
    checkOutput("s4_drop_cnt", int'(dropCnt), 12);
    waitDone("s4_done_timeout", 5);

    // Saturation statistics
    $display("[TB] saturation stats");
    cicValidOut = 1'b1; cicOverflow = 1'b1;
    tick(); tick(); tick();
    checkOutput("s5_sat_cnt3", int'(satCnt), 3);
    checkOutput("s5_sticky", int'(satSticky), 1);
    statClr = 1'b1;
    tick();
    statClr = 1'b0; cicValidOut = 1'b0; cicOverflow = 1'b0;
    checkOutput("s5_clr_inc_cnt", int'(satCnt), 1);
    checkOutput("s5_clr_inc_sticky", int'(satSticky), 1);
    checkOutput("s5_clr_drop", int'(dropCnt), 0);
    cicUnderflow = 1'b1;
    tick();
    checkOutput("s5_unqualified", int'(satCnt), 1);
    cicValidOut = 1'b1;
    tick();
    cicValidOut = 1'b0; cicUnderflow = 1'b0;
    checkOutput("s5_underflow", int'(satCnt), 2);
    statClr = 1'b1;
    tick();
    statClr = 1'b0;
    checkOutput("s5_clr_cnt", int'(satCnt), 0);
    checkOutput("s5_clr_sticky", int'(satSticky), 0);
    cicValidOut = 1'b1; cicOverflow = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    cicValidOut = 1'b0; cicOverflow = 1'b0;
    checkOutput("s5_saturated", int'(satCnt), 15);

    // Reset during FLUSH aborts the change
    $display("[TB] reset mid-flush");
    sValid = 1'b1;
    applyStimulus(4, 1'b0, 0, 0, 1'b0);
    n = 0;
    while (cicRstN && n < 60) begin
      tick();
      n++;
    end
    checkOutput("s7_reach_flush", int'(cicRstN), 0);
    checkOutput("s7_drop_before", int'(dropCnt), 4);
    rstN = 1'b0;
    #1;
    checkOutput("s7_in_rst_cic_rst_n", int'(cicRstN), 0);
    checkOutput("s7_in_rst_busy", int'(busy), 0);
    checkOutput("s7_in_rst_dec", int'(cicDecFactor), 1);
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("s7_busy", int'(busy), 0);
    checkOutput("s7_dec", int'(cicDecFactor), 1);
    checkOutput("s7_cic_rst_n", int'(cicRstN), 1);
    checkOutput("s7_sat_cnt", int'(satCnt), 0);
    checkOutput("s7_drop_cnt", int'(dropCnt), 0);
    checkOutput("s7_sticky", int'(satSticky), 0);
    sValid = 1'b0;
    tick(); tick();

    // Controller still works after the aborted change
    $display("[TB] factor 1 -> 2 after reset");
    applyStimulus(2, 1'b0, 2, 7, 1'b1);
    waitDone("s8_done_timeout", 20);
    checkOutput("s8_dec", int'(cicDecFactor), 2);
    tick(); tick();
    checkOutput("sb_empty", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/cic_dec_ctrl.md
# cic_dec_ctrl

Run-time controller for the CIC decimator. It accepts decimation-factor change requests and lets the current decimation frame finish. It then drains and flushes the CIC before applying the new factor, so no output sample ever mixes two factors. It sits between the sample source and the CIC, gates the CIC's valid_in, and drives its dec_factor and a flush reset. It also collects saturation and dropped-sample statistics from the CIC.

## Interface
Parameters:
- DEC_WIDTH, 4: width of the factor port is DEC_WIDTH+1; matches the CIC.
- DEFAULT_DEC, 1: factor applied out of reset.
- DRAIN_CYCLES, 4: idle cycles after the last accepted sample; must be ≥ CIC pipeline depth (Q+2).
- FLUSH_CYCLES, 2: cycles cic_rst_n is held low.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock (single clock domain).
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  factor-change request.
- cfg_dec_factor  in  DEC_WIDTH+1  requested factor.
- cfg_ready  out  1  request can be accepted.
- cfg_err  out  1  one-cycle pulse: illegal factor rejected.
- cfg_done  out  1  one-cycle pulse: new factor active.
- s_valid  in  1  upstream sample strobe (no back-pressure).
- cic_valid_in  out  1  gated strobe to the CIC.
- cic_dec_factor  out  DEC_WIDTH+1  factor to the CIC.
- cic_rst_n  out  1  registered flush reset to the CIC, active low.
- cic_overflow, cic_underflow  in  1  CIC saturation flags, qualified by cic_valid_out.
- cic_valid_out  in  1  CIC output strobe.
- busy  out  1  reconfiguration in progress.
- sat_sticky  out  1  any saturation since last clear.
- sat_cnt  out  CNT_WIDTH  saturating count of saturated outputs.
- drop_cnt  out  CNT_WIDTH  saturating count of samples dropped during reconfiguration.
- stat_clr  in  1  clears sat_sticky, sat_cnt and drop_cnt.

## Operation
- States: RUN, WAIT_BND, DRAIN, FLUSH.
- Phase counter: mirrors the CIC counter. It advances on each cic_valid_in and wraps at cic_dec_factor-1.
- Legal factors are 1, 2, 4, 8 and 16. Any other value is rejected:
  - cfg_err pulses the next cycle.
  - The state and factor are unchanged.
- RUN:
  - cfg_ready=1 and cic_valid_in=s_valid.
  - A legal request equal to the current factor is accepted with a cfg_done pulse and no flush.
  - A legal request with a different factor is latched into pending. The next state is DRAIN if phase==0, otherwise WAIT_BND.
- WAIT_BND:
  - Samples keep being forwarded.
  - The accepted sample at phase==dec-1 completes the frame; the next state is DRAIN.
- DRAIN:
  - cic_valid_in=0 and each s_valid increments drop_cnt.
  - The state lasts DRAIN_CYCLES cycles, then goes to FLUSH.
- FLUSH:
  - cic_rst_n=0 and samples are dropped and counted.
  - cic_dec_factor is loaded with pending on FLUSH entry.
  - After FLUSH_CYCLES cycles: cic_rst_n=1, phase=0, the state returns to RUN and cfg_done pulses.
- busy=1 in every state except RUN. cfg_ready=0 while busy.
- Statistics:
  - sat_cnt increments when cic_valid_out && (cic_overflow || cic_underflow).
  - Both counters saturate at all-ones and do not wrap.
  - If stat_clr and an event occur in the same cycle, the counter ends at 1 and sat_sticky ends at 1 (set wins).

## Timing
- Reset values:
  - State RUN, cic_dec_factor=DEFAULT_DEC, phase=0.
  - cic_rst_n=0 during reset, then 1 the first cycle after rst_n rises.
  - cfg_ready=1; cfg_err, cfg_done and busy are 0.
  - Counters and sat_sticky are 0.
- cic_valid_in is combinational from s_valid and the state: zero latency in RUN and WAIT_BND.
- cfg_err and cfg_done are registered, one cycle after their cause.
- cfg_ready drops the cycle after an accepted differing request.
- Reconfiguration latency from acceptance at phase 0 is 1 + DRAIN_CYCLES + FLUSH_CYCLES cycles to cfg_done (7 at defaults). Add the remaining frame samples when phase≠0.
- cic_rst_n is driven from a flop; it is never combinational.
- rst_n asserted mid-reconfiguration aborts it; pending is discarded and DEFAULT_DEC is restored.
- With factor 1, phase is always 0, so a change never enters WAIT_BND.

## Structure
- Package cic_ctrl_pkg:
  - State enum.
  - is_legal_dec() function.
  - DEC_WIDTH constant shared with the CIC.
- Sub-module sat_counter (CNT_WIDTH, inc, clr, count; saturating, clear+inc yields 1), instantiated for sat_cnt and drop_cnt.

## Test plan
- Reset, then request factor 4 at phase 0 with continuous s_valid:
  - cfg_done after 7 cycles.
  - drop_cnt=6 (DRAIN 4 + FLUSH 2).
  - cic_dec_factor=4 and cic_rst_n low exactly 2 cycles.
- Factor 8, request 2 at phase 3:
  - 4 more samples forwarded (phase 4..7), then DRAIN.
  - No cic_valid_in between WAIT_BND exit and cfg_done.
- Request factor 6:
  - cfg_err pulse one cycle later.
  - cic_dec_factor unchanged, busy stays 0.
- Request equal to the current factor 16: cfg_done next cycle, no cic_rst_n pulse, drop_cnt unchanged.
- Drive cic_valid_out with overflow 3 times, then stat_clr together with a 4th: sat_cnt=1, sat_sticky=1.
- Assert rst_n low mid-FLUSH: after release, cic_dec_factor=1, busy=0, counters 0.
